instruction_issue: RTL and testbench

Instruction fetch/issue front end. It reads 64-bit instructions from the instruction RAM (1-cycle read latency) and presents each one to the instruction decoder as a single-cycle `instruction`/`instr_enable` pulse. Issue blocks on long-running opcodes until the matching completion pulse arrives: data fetch waits for `fetch_done`, CONV waits for `conv_done`, and system hold waits for `resume`. The null instruction halts the sequencer.

---
 rtl/instruction_issue_if.sv | 29 ++
 rtl/instruction_issue.sv | 146 ++++++++++++++
 tb/tb_instruction_issue.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_issue_if.sv
// Bus between the issue sequencer, the instruction RAM read port and the decoder.
// Neither side has a ready signal. instr_rd_data is valid exactly one cycle after instr_rd_en.
// instr_enable is a one-cycle strobe that the decoder must take, and instruction is 0 whenever it is low.
interface instruction_issue_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 64
);
    logic               instr_rd_en;
    logic [ADDR_W-1:0]  instr_rd_addr;
    logic [INSTR_W-1:0] instr_rd_data;
    logic [INSTR_W-1:0] instruction;
    logic               instr_enable;

    modport master (
        output instr_rd_en,
        output instr_rd_addr,
        input  instr_rd_data,
        output instruction,
        output instr_enable
    );

    modport slave (
        input  instr_rd_en,
        input  instr_rd_addr,
        output instr_rd_data,
        input  instruction,
        input  instr_enable
    );
endinterface

// File: rtl/instruction_issue.sv
// Instruction fetch/issue front end: reads one instruction per READ/DATA/ISSUE pass and
// blocks on fetch, CONV and system-hold opcodes until the matching completion pulse.
module instruction_issue #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    instruction_issue_if.master bus,
    input  logic                fetch_done,
    input  logic                conv_done,
    input  logic                resume,
    output logic                busy,
    output logic                halted,
    output logic [15:0]         issue_count,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_READ        = 3'd1,
        S_DATA        = 3'd2,
        S_ISSUE       = 3'd3,
        S_WAIT_FETCH  = 3'd4,
        S_WAIT_CONV   = 3'd5,
        S_WAIT_RESUME = 3'd6,
        S_HALT        = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic [15:0]        count_q, count_d;
    logic               fetch_flag_q, fetch_flag_d;
    logic               conv_flag_q, conv_flag_d;
    logic               resume_flag_q, resume_flag_d;
    logic [7:0]         opcode;
    logic               op_fetch, op_conv, op_hold;

    assign opcode   = instr_q[INSTR_W-1 -: 8];
    assign op_fetch = (opcode == 8'h02) || (opcode == 8'h04);
    assign op_conv  = (opcode == 8'h81);
    assign op_hold  = (opcode == 8'h44);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        en_d     = 1'b0;
        count_d  = count_q;
        // A done pulse arms its flag only while the matching opcode sits in ISSUE or in its
        // own wait state, so a pulse seen anywhere else cannot release a later wait.
        fetch_flag_d  = fetch_flag_q  | (fetch_done & ((state_q == S_WAIT_FETCH)  | ((state_q == S_ISSUE) & op_fetch)));
        conv_flag_d   = conv_flag_q   | (conv_done  & ((state_q == S_WAIT_CONV)   | ((state_q == S_ISSUE) & op_conv)));
        resume_flag_d = resume_flag_q | (resume     & ((state_q == S_WAIT_RESUME) | ((state_q == S_ISSUE) & op_hold)));

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = start_addr;
                    count_d = 16'd0;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_DATA;
            S_DATA: begin
                instr_d = bus.instr_rd_data;
                en_d    = 1'b1;
                pc_d    = pc_q + ADDR_W'(1);
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                instr_d = '0;
                if (opcode == 8'h82)  state_d = S_HALT;
                else if (op_fetch)    state_d = S_WAIT_FETCH;
                else if (op_conv)     state_d = S_WAIT_CONV;
                else if (op_hold)     state_d = S_WAIT_RESUME;
                else                  state_d = S_READ;
            end
            S_WAIT_FETCH: begin
                if (fetch_flag_q || fetch_done) begin
                    fetch_flag_d = 1'b0;
                    state_d      = S_READ;
                end
            end
            S_WAIT_CONV: begin
                if (conv_flag_q || conv_done) begin
                    conv_flag_d = 1'b0;
                    state_d     = S_READ;
                end
            end
            S_WAIT_RESUME: begin
                if (resume_flag_q || resume) begin
                    resume_flag_d = 1'b0;
                    state_d       = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            en_q          <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            count_q       <= 16'd0;
            fetch_flag_q  <= 1'b0;
            conv_flag_q   <= 1'b0;
            resume_flag_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            en_q          <= en_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            count_q       <= count_d;
            fetch_flag_q  <= fetch_flag_d;
            conv_flag_q   <= conv_flag_d;
            resume_flag_q <= resume_flag_d;
        end
    end

    assign bus.instr_rd_en   = (state_q == S_READ);
    assign bus.instr_rd_addr = (state_q == S_READ) ? pc_q : '0;
    assign bus.instruction   = instr_q;
    assign bus.instr_enable  = en_q;
    assign busy              = busy_q;
    assign halted            = halted_q;
    assign issue_count       = count_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_instruction_issue.sv
// Directed bench for instruction_issue: halting sequence, blocking waits, PC wrap,
// mid-operation reset and start handling, against a 16-entry instruction RAM.
module tb_instruction_issue;

    localparam int AW = 4;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_READ = 3'd1, ST_ISSUE = 3'd3,
                           ST_WFETCH = 3'd4, ST_WCONV = 3'd5, ST_WRES = 3'd6, ST_HALT = 3'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          fetch_done = 1'b0, conv_done = 1'b0, resume = 1'b0;
    logic          busy, halted;
    logic [15:0]   issue_count;
    logic [2:0]    state_dbg;
    logic [63:0]   ram [16];
    int            checks = 0;
    int            errors = 0;

    instruction_issue_if #(.ADDR_W(AW), .INSTR_W(64)) bus ();

    instruction_issue #(.ADDR_W(AW), .INSTR_W(64)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .bus(bus),
        .fetch_done(fetch_done), .conv_done(conv_done), .resume(resume),
        .busy(busy), .halted(halted), .issue_count(issue_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.instr_rd_en) bus.instr_rd_data <= ram[bus.instr_rd_addr];
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] addr);
        start = 1'b1;
        start_addr = addr;
        cycle();
        start = 1'b0;
    endtask

    // Advances until instr_enable is seen; n is the number of edges taken, -1 on timeout.
    task automatic wait_en(input int max, output int n);
        n = 0;
        while (n < max) begin
            cycle();
            n++;
            if (bus.instr_enable === 1'b1) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
        checks++; if ({busy, halted, bus.instr_enable, bus.instr_rd_en} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, halted, bus.instr_enable, bus.instr_rd_en}); end
        checks++; if (bus.instruction !== 64'd0 || issue_count !== 16'd0) begin errors++; $display("FAIL reset_data got=%h/%0d exp=0/0", bus.instruction, issue_count); end
    endtask

    task automatic test_basic_halt();
        int n;
        ram[0] = 64'h4001_0100_0000_0000;
        ram[1] = 64'h0100_0000_0000_00AA;
        ram[2] = 64'h8200_0000_0000_0000;
        do_start(0);
        checks++; if (bus.instr_rd_en !== 1'b1 || bus.instr_rd_addr !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL basic_read got=%b/%0d/%b exp=1/0/1", bus.instr_rd_en, bus.instr_rd_addr, busy); end
        wait_en(10, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL basic_lat0 got=%0d exp=2", n); end
        checks++; if (bus.instruction !== ram[0] || issue_count !== 16'd1) begin errors++; $display("FAIL basic_word0 got=%h/%0d exp=%h/1", bus.instruction, issue_count, ram[0]); end
        cycle();
        checks++; if (bus.instruction !== 64'd0 || bus.instr_enable !== 1'b0) begin errors++; $display("FAIL basic_gap got=%h/%b exp=0/0", bus.instruction, bus.instr_enable); end
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instruction !== ram[1]) begin errors++; $display("FAIL basic_word1 got=%0d/%h exp=2/%h", n, bus.instruction, ram[1]); end
        wait_en(10, n);
        checks++; if (n !== 3 || bus.instruction !== ram[2]) begin errors++; $display("FAIL basic_word2 got=%0d/%h exp=3/%h", n, bus.instruction, ram[2]); end
        cycle();
        checks++; if (halted !== 1'b1 || busy !== 1'b0 || state_dbg !== ST_HALT) begin errors++; $display("FAIL basic_halt got=%b/%b/%0d exp=1/0/7", halted, busy, state_dbg); end
        checks++; if (issue_count !== 16'd3 || bus.instruction !== 64'd0) begin errors++; $display("FAIL basic_count got=%0d/%h exp=3/0", issue_count, bus.instruction); end
    endtask

    task automatic test_wait_fetch();
        int n;
        int seen = 0;
        ram[5] = 64'h0200_0000_0000_0005;
        ram[6] = 64'h8200_0000_0000_0006;
        do_start(5);
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instruction !== ram[5]) begin errors++; $display("FAIL fetch_issue got=%0d/%h exp=2/%h", n, bus.instruction, ram[5]); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) conv_done = 1'b1;
            cycle();
            conv_done = 1'b0;
            if (bus.instr_enable === 1'b1) seen++;
        end
        checks++; if (seen !== 0 || state_dbg !== ST_WFETCH) begin errors++; $display("FAIL fetch_block got=%0d/%0d exp=0/%0d", seen, state_dbg, ST_WFETCH); end
        fetch_done = 1'b1;
        cycle();
        fetch_done = 1'b0;
        checks++; if (state_dbg !== ST_READ) begin errors++; $display("FAIL fetch_release got=%0d exp=%0d", state_dbg, ST_READ); end
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instruction !== ram[6] || issue_count !== 16'd2) begin errors++; $display("FAIL fetch_next got=%0d/%h/%0d exp=2/%h/2", n, bus.instruction, issue_count, ram[6]); end
        cycle();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL fetch_halt got=%b exp=1", halted); end
    endtask

    task automatic test_wait_conv();
        int n;
        int seen = 0;
        ram[8]  = 64'h8100_0000_0000_0008;
        ram[9]  = 64'h0100_0000_0000_0009;
        ram[10] = 64'h8100_0000_0000_000A;
        ram[11] = 64'h8200_0000_0000_000B;
        do_start(8);
        conv_done = 1'b1;
        cycle();
        conv_done = 1'b0;
        cycle();
        checks++; if (bus.instr_enable !== 1'b1 || bus.instruction !== ram[8]) begin errors++; $display("FAIL conv_issue got=%b/%h exp=1/%h", bus.instr_enable, bus.instruction, ram[8]); end
        conv_done = 1'b1;
        cycle();
        conv_done = 1'b0;
        checks++; if (state_dbg !== ST_WCONV) begin errors++; $display("FAIL conv_wait got=%0d exp=%0d", state_dbg, ST_WCONV); end
        wait_en(10, n);
        checks++; if (n !== 3 || bus.instruction !== ram[9]) begin errors++; $display("FAIL conv_same_cycle got=%0d/%h exp=3/%h", n, bus.instruction, ram[9]); end
        conv_done = 1'b1;
        cycle();
        cycle();
        conv_done = 1'b0;
        cycle();
        checks++; if (bus.instr_enable !== 1'b1 || bus.instruction !== ram[10]) begin errors++; $display("FAIL conv_issue2 got=%b/%h exp=1/%h", bus.instr_enable, bus.instruction, ram[10]); end
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus.instr_enable === 1'b1) seen++;
        end
        checks++; if (seen !== 0 || state_dbg !== ST_WCONV) begin errors++; $display("FAIL conv_prearm got=%0d/%0d exp=0/%0d", seen, state_dbg, ST_WCONV); end
        conv_done = 1'b1;
        cycle();
        conv_done = 1'b0;
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instruction !== ram[11]) begin errors++; $display("FAIL conv_next got=%0d/%h exp=2/%h", n, bus.instruction, ram[11]); end
        cycle();
        checks++; if (halted !== 1'b1 || issue_count !== 16'd4) begin errors++; $display("FAIL conv_halt got=%b/%0d exp=1/4", halted, issue_count); end
    endtask

    task automatic test_pc_wrap();
        int n;
        ram[15] = 64'h4000_0000_0000_000F;
        ram[0]  = 64'h8200_0000_0000_0010;
        do_start(15);
        checks++; if (bus.instr_rd_en !== 1'b1 || bus.instr_rd_addr !== 4'd15) begin errors++; $display("FAIL wrap_addr15 got=%b/%0d exp=1/15", bus.instr_rd_en, bus.instr_rd_addr); end
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instruction !== ram[15]) begin errors++; $display("FAIL wrap_word15 got=%0d/%h exp=2/%h", n, bus.instruction, ram[15]); end
        cycle();
        checks++; if (bus.instr_rd_en !== 1'b1 || bus.instr_rd_addr !== 4'd0) begin errors++; $display("FAIL wrap_addr0 got=%b/%0d exp=1/0", bus.instr_rd_en, bus.instr_rd_addr); end
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instruction !== ram[0]) begin errors++; $display("FAIL wrap_word0 got=%0d/%h exp=2/%h", n, bus.instruction, ram[0]); end
        cycle();
        checks++; if (halted !== 1'b1 || issue_count !== 16'd2) begin errors++; $display("FAIL wrap_halt got=%b/%0d exp=1/2", halted, issue_count); end
    endtask

    task automatic test_mid_reset();
        int n;
        ram[3] = 64'h8100_0000_0000_0003;
        do_start(3);
        wait_en(10, n);
        cycle();
        checks++; if (state_dbg !== ST_WCONV) begin errors++; $display("FAIL rst_setup got=%0d exp=%0d", state_dbg, ST_WCONV); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if ({state_dbg, busy, halted, bus.instr_enable, bus.instr_rd_en} !== 7'b0 || bus.instruction !== 64'd0 || issue_count !== 16'd0) begin errors++; $display("FAIL rst_in_wait got=%0d/%b/%b/%b/%h/%0d exp=0/0/0/0/0/0", state_dbg, busy, halted, bus.instr_enable, bus.instruction, issue_count); end
        do_start(3);
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instr_enable !== 1'b1) begin errors++; $display("FAIL rst_reissue got=%0d/%b exp=2/1", n, bus.instr_enable); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if ({state_dbg, busy, halted, bus.instr_enable, bus.instr_rd_en} !== 7'b0 || bus.instruction !== 64'd0 || issue_count !== 16'd0) begin errors++; $display("FAIL rst_in_issue got=%0d/%b/%b/%b/%h/%0d exp=0/0/0/0/0/0", state_dbg, busy, halted, bus.instr_enable, bus.instruction, issue_count); end
        rst = 1'b1;
        start = 1'b1;
        start_addr = 4'd3;
        cycle();
        rst = 1'b0;
        start = 1'b0;
        checks++; if (state_dbg !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL rst_beats_start got=%0d/%b exp=0/0", state_dbg, busy); end
        ram[3] = 64'h4000_0000_0000_0033;
        ram[4] = 64'h8200_0000_0000_0044;
        do_start(3);
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instruction !== ram[3] || issue_count !== 16'd1) begin errors++; $display("FAIL rst_restart got=%0d/%h/%0d exp=2/%h/1", n, bus.instruction, issue_count, ram[3]); end
        wait_en(10, n);
        cycle();
        checks++; if (halted !== 1'b1 || issue_count !== 16'd2) begin errors++; $display("FAIL rst_restart_halt got=%b/%0d exp=1/2", halted, issue_count); end
    endtask

    task automatic test_resume_restart();
        int n;
        ram[12] = 64'h4400_0000_0000_000C;
        ram[13] = 64'h8200_0000_0000_000D;
        do_start(12);
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instruction !== ram[12]) begin errors++; $display("FAIL res_issue got=%0d/%h exp=2/%h", n, bus.instruction, ram[12]); end
        cycle();
        start = 1'b1;
        start_addr = 4'd0;
        fetch_done = 1'b1;
        cycle();
        start = 1'b0;
        fetch_done = 1'b0;
        cycle();
        checks++; if (state_dbg !== ST_WRES || busy !== 1'b1 || issue_count !== 16'd1) begin errors++; $display("FAIL res_start_ignored got=%0d/%b/%0d exp=%0d/1/1", state_dbg, busy, issue_count, ST_WRES); end
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instruction !== ram[13]) begin errors++; $display("FAIL res_next got=%0d/%h exp=2/%h", n, bus.instruction, ram[13]); end
        cycle();
        checks++; if (halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL res_halt got=%b/%b exp=1/0", halted, busy); end
        do_start(0);
        checks++; if (halted !== 1'b0 || busy !== 1'b1 || state_dbg !== ST_READ || issue_count !== 16'd0) begin errors++; $display("FAIL halt_restart got=%b/%b/%0d/%0d exp=0/1/1/0", halted, busy, state_dbg, issue_count); end
        wait_en(10, n);
        checks++; if (n !== 2 || bus.instruction !== ram[0] || issue_count !== 16'd1) begin errors++; $display("FAIL halt_reissue got=%0d/%h/%0d exp=2/%h/1", n, bus.instruction, issue_count, ram[0]); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 64'd0;
        test_reset();
        test_basic_halt();
        test_wait_fetch();
        test_wait_conv();
        test_pc_wrap();
        test_mid_reset();
        test_resume_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
